instruction_fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of `instruction_decode`. It holds the program counter and issues word-aligned requests to instruction memory over a request/grant/response interface. Returned words are buffered, paired with their PC, in a small in-order FIFO, and presented to the decoder through a valid/ready handshake. A redirect input from the branch/jump resolution logic flushes in-flight work and restarts fetch at a new PC.

---
 rtl/instruction_fetch.sv | 121 ++++++++++++
 tb/tb_instruction_fetch.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: program counter, request/grant/response fetch from
// instruction memory, and an in-order {pc, instr} buffer feeding decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN adds a sticky misalign_err
// output that flags redirects to non-word-aligned targets.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    input  logic        instr_ready,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        misalign_err,
`endif
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [31:0]    NOP     = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    fetch_entry_t       fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count, outstanding, discard;
    logic [31:0]        fetch_pc, resp_pc;
    logic [31:0]        redirect_tgt;
    logic [CNT_W:0]     inflight;
    logic               pop, push, drop, grant;

    // Fetch always targets a word boundary; the low bits of a redirect are
    // either trapped (feature enabled) or simply ignored.
    assign redirect_tgt = {redirect_pc[31:2], 2'b00};
`ifndef FETCH_MISALIGN_TRAP_EN
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready;
    // Credit: every granted request must already own a buffer slot, counting
    // the slot freed by this cycle's pop.
    assign inflight    = {1'b0, outstanding} + {1'b0, count} - (CNT_W+1)'(pop);
    assign imem_req    = rst_n && !redirect_valid && (inflight < DEPTH_C);
    assign imem_addr   = fetch_pc;
    assign grant       = imem_req && imem_gnt;
    assign push        = !redirect_valid && imem_rvalid && (discard == '0);
    assign drop        = !redirect_valid && imem_rvalid && (discard != '0);

    assign instr_out   = instr_valid ? fifo_q[rd_ptr].instr : NOP;
    assign pc_out      = instr_valid ? fifo_q[rd_ptr].pc    : 32'h0;

    // PC, outstanding-request and discard bookkeeping; redirect wins.
    // outstanding already includes requests pending discard, so on redirect
    // every unreturned request (old or new) becomes a discard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_tgt;
            resp_pc     <= redirect_tgt;
            outstanding <= outstanding - CNT_W'(imem_rvalid);
            discard     <= outstanding - CNT_W'(imem_rvalid);
        end else begin
            if (grant) fetch_pc <= fetch_pc + 32'd4;
            if (push)  resp_pc  <= resp_pc + 32'd4;
            if (drop)  discard  <= discard - CNT_W'(1);
            outstanding <= outstanding + CNT_W'(grant) - CNT_W'(imem_rvalid);
        end
    end

    // Buffer pointers and occupancy; a redirect empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Buffer storage; contents are only visible through count, so no reset.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr] <= {resp_pc, imem_rdata};
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Sticky flag for a redirect to a non-word-aligned target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            misalign_err <= 1'b0;
        else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
            misalign_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory model returning mem[a]=a with variable
// latency, and a reference model of buffered PCs tracked as queues.
module tb_instruction_fetch;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'h0;
    logic [31:0] instr_out, pc_out;
    logic        instr_valid, instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    instruction_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
        .instr_ready(instr_ready),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misalign_err(misalign_err),
`endif
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } resp_t;

    typedef struct {
        logic [31:0] rpc;
        int          lat;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    resp_t       rq[$];     // granted, not yet returned
    logic [31:0] mq[$];     // PCs expected in the fetch buffer, head first
    logic [31:0] mfpc, exp_next;
    int          cyc = 0, last_due = -1, lat = 1;
    int          checks = 0, errors = 0;

    // per-step stimulus and sampled values
    bit          rst_v = 0, rdy_v = 0, gnt_v = 0, redir_v = 0;
    logic [31:0] rpc_v = 32'h0;
    logic        s_valid, s_req;
    logic [31:0] s_pc, s_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive at the falling edge, check, then advance the model to
    // the state expected after the next rising edge.
    task automatic step();
        bit    mrv, mpop;
        int    due, eocc;
        resp_t r;
        @(negedge clk);
        if (!rst_v) begin
            rq.delete(); mq.delete();
            mfpc = 32'h0; exp_next = 32'h0; last_due = -1;
        end
        mrv = rst_v && (rq.size() > 0) && (rq[0].due <= cyc);
        rst_n          = rst_v;
        imem_rvalid    = mrv;
        imem_rdata     = mrv ? rq[0].addr : 32'hDEAD_BEEF;
        imem_gnt       = gnt_v;
        instr_ready    = rdy_v;
        redirect_valid = redir_v;
        redirect_pc    = rpc_v;
        #1;
        s_valid = instr_valid; s_req = imem_req; s_pc = pc_out; s_instr = instr_out;
        if (!rst_v) begin
            chk("rst_req", {31'h0, imem_req}, 32'h0);
            chk("rst_valid", {31'h0, instr_valid}, 32'h0);
            chk("rst_instr", instr_out, NOP);
            chk("rst_pc", pc_out, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
            chk("rst_misalign", {31'h0, misalign_err}, 32'h0);
`endif
        end else begin
            chk("valid", {31'h0, instr_valid}, {31'h0, mq.size() != 0});
            if (mq.size() != 0) begin
                chk("pc_out", pc_out, mq[0]);
                chk("instr_out", instr_out, mq[0]);
            end else begin
                chk("empty_instr", instr_out, NOP);
                chk("empty_pc", pc_out, 32'h0);
            end
            mpop = (mq.size() != 0) && rdy_v;
            eocc = rq.size() + mq.size() - int'(mpop);
            chk("req", {31'h0, imem_req}, {31'h0, !redir_v && (eocc < DEPTH)});
            if (imem_req) chk("addr", imem_addr, mfpc);
            if (redir_v) begin
                foreach (rq[i]) rq[i].stale = 1;
                if (mrv) void'(rq.pop_front());
                mq.delete();
                mfpc = {rpc_v[31:2], 2'b00};
                exp_next = mfpc;
            end else begin
                if (mpop) begin
                    chk("order", pc_out, exp_next);
                    exp_next += 32'd4;
                    void'(mq.pop_front());
                end
                if (mrv) begin
                    r = rq.pop_front();
                    if (!r.stale) mq.push_back(r.addr);
                end
                if (imem_req && gnt_v) begin
                    due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                    rq.push_back('{addr: imem_addr, due: due, stale: 0});
                    last_due = due;
                    mfpc += 32'd4;
                end
            end
        end
        cyc++;
    endtask

    vec_t vecs[5];

    initial begin
        int k, pops;
        vecs[0] = '{32'h0000_0100, 3, 32'h0000_0100, 32'h0000_0100};
        vecs[1] = '{32'h0000_0200, 1, 32'h0000_0200, 32'h0000_0200};
        vecs[2] = '{32'h0000_0103, 2, 32'h0000_0100, 32'h0000_0100};
        vecs[3] = '{32'hFFFF_FFF8, 1, 32'hFFFF_FFF8, 32'hFFFF_FFF8};
        vecs[4] = '{32'h0000_0040, 3, 32'h0000_0040, 32'h0000_0040};

        // reset held, then 1-cycle memory with decoder always ready
        rst_v = 0; gnt_v = 1; rdy_v = 1; lat = 1;
        repeat (3) step();
        rst_v = 1;
        k = 0;
        do begin step(); k++; end while (!s_valid && k < 10);
        chk("first_valid_cycle", k, 3);
        chk("first_pc", s_pc, 32'h0);
        pops = 0;
        repeat (10) begin step(); if (s_valid) pops++; end
        chk("throughput", pops, 10);

        // decoder stalls: buffer fills and requests stop
        rdy_v = 0;
        repeat (10) step();
        chk("stall_valid", {31'h0, s_valid}, 32'h1);
        chk("stall_req", {31'h0, s_req}, 32'h0);
        rdy_v = 1;
        repeat (10) step();

        // redirect coinciding with rvalid and pop in steady state
        redir_v = 1; rpc_v = 32'h0000_0300; step();
        redir_v = 0;
        step();
        chk("redir_flush", {31'h0, s_valid}, 32'h0);
        repeat (6) step();

`ifdef FETCH_MISALIGN_TRAP_EN
        chk("misalign_clear", {31'h0, misalign_err}, 32'h0);
        redir_v = 1; rpc_v = 32'h0000_0102; step();
        redir_v = 0;
        step();
        chk("misalign_set", {31'h0, misalign_err}, 32'h1);
        k = 0;
        do begin step(); k++; end while (!s_valid && k < 20);
        chk("misalign_resume", s_pc, 32'h0000_0100);
`endif

        // table: redirects at various latencies, including wrap-around
        foreach (vecs[i]) begin
            lat = vecs[i].lat;
            repeat (8) step();
            redir_v = 1; rpc_v = vecs[i].rpc; step();
            redir_v = 0;
            k = 0;
            do begin step(); k++; end while (!s_valid && k < 20);
            chk("vec_valid", {31'h0, s_valid}, 32'h1);
            chk("vec_pc", s_pc, vecs[i].exp_pc);
            chk("vec_instr", s_instr, vecs[i].exp_instr);
            if (vecs[i].lat == 1) chk("vec_redir_latency", k, 3);
            repeat (4) step();
        end

        // reset while a request waits for grant
        lat = 2; gnt_v = 0;
        k = 0;
        do begin step(); k++; end while (!s_req && k < 10);
        rst_v = 0; step();
        chk("midrst_req", {31'h0, s_req}, 32'h0);
        chk("midrst_valid", {31'h0, s_valid}, 32'h0);
        rst_v = 1; gnt_v = 1; step();
        chk("restart_req", {31'h0, s_req}, 32'h1);
        chk("restart_addr", imem_addr, 32'h0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (n % 100 == 0) lat = int'($urandom_range(1, 3));
            rdy_v   = ($urandom % 4) != 0;
            gnt_v   = ($urandom % 4) != 0;
            redir_v = ($urandom % 16) == 0;
            rpc_v   = $urandom & 32'h0000_FFFF;
            rst_v   = ($urandom % 500) != 0;
            step();
        end
        rst_v = 1; redir_v = 0; rdy_v = 1; gnt_v = 1;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
